// File: rtl/knight_cmd_link.sv
// rtl/knight_cmd_link.sv - Knight's Tour UART command link endpoint
module knight_cmd_link #(
    parameter int BAUD_DIV     = 2604,
    parameter int BYTE_TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int TW = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(BYTE_TIMEOUT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {AS_HIGH, AS_LOW}                     as_state_t;
    typedef enum logic       {TX_IDLE, TX_BUSY}                    tx_state_t;

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [BW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bits_q, rx_bits_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            byte_rdy_q, byte_rdy_d;

    as_state_t       as_state_q, as_state_d;
    logic [7:0]      hi_buf_q, hi_buf_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [15:0]     cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;

    tx_state_t       tx_state_q, tx_state_d;
    logic [BW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bits_q, tx_bits_d;
    logic [8:0]      tx_shift_q, tx_shift_d;
    logic            tx_line_q, tx_line_d;
    logic            tx_done_q, tx_done_d;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection; idle-high on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver next state: mid-bit sampling, glitch rejection in START, framing check in STOP
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bits_d  = rx_bits_q;
        rx_shift_d = rx_shift_q;
        byte_rdy_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_LAST;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = BAUD_LAST;
                        rx_bits_d  = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - BW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = BAUD_LAST;
                    if (rx_bits_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bits_d = rx_bits_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - BW'(1);
                end
            end
            default: begin
                if (rx_cnt_q == '0) begin
                    byte_rdy_d = rx_sync_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - BW'(1);
                end
            end
        endcase
    end

    // Receiver state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bits_q  <= 3'd0;
            rx_shift_q <= 8'h00;
            byte_rdy_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bits_q  <= rx_bits_d;
            rx_shift_q <= rx_shift_d;
            byte_rdy_q <= byte_rdy_d;
        end
    end

    // Assembler next state: pair bytes high-then-low, drop a stale high byte on timeout
    always_comb begin
        as_state_d = as_state_q;
        hi_buf_d   = hi_buf_q;
        tmo_d      = tmo_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        case (as_state_q)
            AS_HIGH: begin
                if (byte_rdy_q) begin
                    hi_buf_d   = rx_shift_q;
                    tmo_d      = '0;
                    cmd_rdy_d  = 1'b0;
                    as_state_d = AS_LOW;
                end
            end
            default: begin
                if (byte_rdy_q) begin
                    cmd_d      = {hi_buf_q, rx_shift_q};
                    cmd_rdy_d  = 1'b1;
                    as_state_d = AS_HIGH;
                end else if (tmo_q == TMO_MAX) begin
                    as_state_d = AS_HIGH;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
        endcase
    end

    // Assembler state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            as_state_q <= AS_HIGH;
            hi_buf_q   <= 8'h00;
            tmo_q      <= '0;
            cmd_q      <= 16'h0000;
            cmd_rdy_q  <= 1'b0;
        end else begin
            as_state_q <= as_state_d;
            hi_buf_q   <= hi_buf_d;
            tmo_q      <= tmo_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
        end
    end

    // Transmitter next state: start bit driven on accept, then data LSB first and stop bit
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bits_d  = tx_bits_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_done_d  = tx_done_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (trmt) begin
                    tx_line_d  = 1'b0;
                    tx_shift_d = {1'b1, resp};
                    tx_bits_d  = 4'd0;
                    tx_cnt_d   = BAUD_LAST;
                    tx_done_d  = 1'b0;
                    tx_state_d = TX_BUSY;
                end
            end
            default: begin
                if (tx_cnt_q == '0) begin
                    if (tx_bits_q == 4'd9) begin
                        tx_line_d  = 1'b1;
                        tx_done_d  = 1'b1;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_line_d  = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[8:1]};
                        tx_bits_d  = tx_bits_q + 4'd1;
                        tx_cnt_d   = BAUD_LAST;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - BW'(1);
                end
            end
        endcase
    end

    // Transmitter state register; line idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bits_q  <= 4'd0;
            tx_shift_q <= 9'h1FF;
            tx_line_q  <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bits_q  <= tx_bits_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign TX      = tx_line_q;
    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_knight_cmd_link.sv
// tb/tb_knight_cmd_link.sv - self-checking bench for knight_cmd_link
`timescale 1ns/1ps
module tb_knight_cmd_link;

    localparam int B   = 16;
    localparam int H   = B / 2;
    localparam int TMO = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        trmt = 1'b0;
    logic        tx_done;

    knight_cmd_link #(.BAUD_DIV(B), .BYTE_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int last_start = 0;
    bit rdy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle at which cmd_rdy rises
    always @(negedge clk) begin
        if (cmd_rdy && !rdy_prev) rise_cyc = cyc;
        rdy_prev = cmd_rdy;
    end

    typedef struct { logic [7:0] hi; logic [7:0] lo; logic [15:0] exp; } rx_vec_t;
    typedef struct { logic [7:0] r; logic [9:0] bits; bit inject; } tx_vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            failures++;
            $display("FAIL %s got=%0d exp=[%0d..%0d]", name, got, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        RX = 1'b0;
        last_start = cyc;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = stop;
        repeat (B) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic send_pair(input logic [7:0] hi, input logic [7:0] lo);
        send_byte(hi, 1'b1);
        idle(5);
        send_byte(lo, 1'b1);
        idle(4);
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr_cmd_rdy = 1'b1;
        @(negedge clk); clr_cmd_rdy = 1'b0;
    endtask

    task automatic tx_frame(input logic [7:0] r, input logic [9:0] exp, input bit inject);
        int n;
        logic [9:0] got;
        got = '0;
        @(negedge clk); resp = r; trmt = 1'b1;
        @(negedge clk); trmt = 1'b0;
        n = 1;
        chk("tx_start_low", TX, 1'b0);
        chk("tx_done_cleared", tx_done, 1'b0);
        for (int i = 0; i < 10; i++) begin
            while (n < i * B + H + 1) begin
                @(negedge clk); n++; trmt = 1'b0;
            end
            got[i] = TX;
            if (inject && i == 4) begin
                resp = ~r; trmt = 1'b1;
            end
        end
        while (n < 10 * B) begin
            @(negedge clk); n++; trmt = 1'b0;
        end
        chk("tx_done_early", tx_done, 1'b0);
        @(negedge clk);
        chk("tx_done_set", tx_done, 1'b1);
        chk("tx_idle_high", TX, 1'b1);
        chk("tx_bits", got, exp);
    endtask

    rx_vec_t rxv[5];
    tx_vec_t txv[4];

    initial begin
        bit          pending;
        bit          exp_rdy;
        bit          quiet;
        logic [7:0]  hi_m;
        logic [7:0]  b;
        logic [15:0] exp_cmd;
        int          gap;
        bit          long_gap;

        rxv[0] = '{8'h20, 8'h00, 16'h2000};
        rxv[1] = '{8'hFF, 8'hFF, 16'hFFFF};
        rxv[2] = '{8'h00, 8'h01, 16'h0001};
        rxv[3] = '{8'hC3, 8'h5A, 16'hC35A};
        rxv[4] = '{8'h80, 8'h7E, 16'h807E};
        txv[0] = '{8'hA5, 10'b1101001010, 1'b1};
        txv[1] = '{8'h00, 10'b1000000000, 1'b0};
        txv[2] = '{8'hFF, 10'b1111111110, 1'b1};
        txv[3] = '{8'h3C, 10'b1001111000, 1'b0};

        // Reset state and idle quiet period
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", TX, 1'b1);
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_cmd_rdy", cmd_rdy, 1'b0);
        chk("rst_tx_done", tx_done, 1'b0);
        quiet = 1'b1;
        for (int i = 0; i < 20 * B; i++) begin
            @(negedge clk);
            if (TX !== 1'b1 || cmd_rdy !== 1'b0 || tx_done !== 1'b0 || cmd !== 16'h0000) quiet = 1'b0;
        end
        chk("idle_quiet", quiet, 1'b1);

        // Command reception table
        for (int i = 0; i < 5; i++) begin
            rise_cyc = 0;
            send_pair(rxv[i].hi, rxv[i].lo);
            chk("rx_cmd", cmd, rxv[i].exp);
            chk("rx_cmd_rdy", cmd_rdy, 1'b1);
            chk_range("rx_latency", rise_cyc - last_start, H + 9 * B + 2, H + 9 * B + 5);
            if (i == 0) begin
                pulse_clr();
                chk("clr_rdy", cmd_rdy, 1'b0);
                chk("clr_cmd_hold", cmd, 16'h2000);
            end
        end

        // Response transmission table
        for (int i = 0; i < 4; i++) begin
            tx_frame(txv[i].r, txv[i].bits, txv[i].inject);
            idle(3);
        end

        // Inter-byte timeout drops the stale high byte
        send_byte(8'h55, 1'b1);
        idle(4);
        chk("tmo_hi_clears_rdy", cmd_rdy, 1'b0);
        chk("tmo_hi_cmd_hold", cmd, 16'h807E);
        idle(TMO + 10);
        chk("tmo_cmd_hold", cmd, 16'h807E);
        send_pair(8'h12, 8'h34);
        chk("tmo_cmd", cmd, 16'h1234);
        chk("tmo_cmd_rdy", cmd_rdy, 1'b1);

        // Glitch and framing error are not bytes
        @(negedge clk); RX = 1'b0;
        idle(B / 4);
        RX = 1'b1;
        idle(2 * B);
        send_byte(8'h77, 1'b0);
        idle(2 * B);
        chk("glitch_cmd_hold", cmd, 16'h1234);
        chk("glitch_rdy_hold", cmd_rdy, 1'b1);
        send_pair(8'hAB, 8'hCD);
        chk("after_glitch_cmd", cmd, 16'hABCD);
        chk("after_glitch_rdy", cmd_rdy, 1'b1);

        // Reset mid low byte with a response in flight
        send_byte(8'h99, 1'b1);
        idle(3);
        @(negedge clk); resp = 8'h3C; trmt = 1'b1;
        @(negedge clk); trmt = 1'b0;
        RX = 1'b0;
        idle(3 * B);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", TX, 1'b1);
        chk("mid_rst_cmd", cmd, 16'h0000);
        chk("mid_rst_rdy", cmd_rdy, 1'b0);
        chk("mid_rst_tx_done", tx_done, 1'b0);
        RX = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(B);
        chk("post_rst_tx", TX, 1'b1);
        send_pair(8'h0F, 8'h0F);
        chk("post_rst_cmd", cmd, 16'h0F0F);
        chk("post_rst_rdy", cmd_rdy, 1'b1);

        // Randomized byte stream against a byte-level pairing model
        pending = 1'b0;
        exp_cmd = 16'h0F0F;
        exp_rdy = 1'b1;
        hi_m    = 8'h00;
        for (int k = 0; k < 30; k++) begin
            b        = 8'($urandom);
            long_gap = ($urandom_range(0, 4) == 0);
            gap      = long_gap ? TMO + 50 : int'($urandom_range(2, 100));
            idle(gap);
            if (long_gap) pending = 1'b0;
            send_byte(b, 1'b1);
            idle(4);
            if (!pending) begin
                pending = 1'b1;
                hi_m    = b;
                exp_rdy = 1'b0;
            end else begin
                exp_cmd = {hi_m, b};
                exp_rdy = 1'b1;
                pending = 1'b0;
            end
            chk("rand_cmd", cmd, exp_cmd);
            chk("rand_rdy", cmd_rdy, exp_rdy);
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                exp_rdy = 1'b0;
                chk("rand_clr", cmd_rdy, exp_rdy);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
